// File: rtl/somador_pkg.sv
// Shared types and defaults for the multi-precision somador sequencer.
package somador_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int NBYTES_DEF  = 4;
  localparam int ADD_LAT_DEF = 1;

endpackage

// File: rtl/somador_seq.sv
// Byte-serial add/subtract sequencer driving an external 8-bit somador.
// Operands are latched on accept; result held on a valid/ack handshake.
module somador_seq
  import somador_pkg::*;
#(
  parameter int NBYTES  = NBYTES_DEF,
  parameter int ADD_LAT = ADD_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  op_i,
  input  logic                  cin_i,
  input  logic [8*NBYTES-1:0]   a_i,
  input  logic [8*NBYTES-1:0]   b_i,
  output logic                  ready_o,
  output logic                  valid_o,
  input  logic                  ack_i,
  output logic [8*NBYTES-1:0]   result_o,
  output logic                  carry_o,
  output logic [7:0]            add_a_o,
  output logic [7:0]            add_b_o,
  output logic                  add_cin_o,
  input  logic [7:0]            add_sum_i,
  input  logic                  add_cout_i
);

  localparam int W = 8 * NBYTES;

  state_t         r_state;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_result;
  logic           r_carry;
  logic           r_cout;
  logic [2:0]     r_k;
  logic [1:0]     r_cnt;
  logic [7:0]     r_add_a;
  logic [7:0]     r_add_b;
  logic           r_add_cin;

  logic [W-1:0]   w_bx;
  logic           w_cin0;
  logic           w_last;
  logic [2:0]     w_knext;
  logic [5:0]     w_knext_ofs;
  logic [5:0]     w_k_ofs;

  // B is stored already inverted for subtract so the datapath only adds.
  assign w_bx        = (op_i == OP_SUB) ? ~b_i : b_i;
  assign w_cin0      = (op_i == OP_SUB) ? 1'b1 : cin_i;
  assign w_last      = (r_k == 3'(NBYTES - 1));
  assign w_knext     = r_k + 3'd1;
  assign w_k_ofs     = {r_k, 3'b000};
  assign w_knext_ofs = {w_knext, 3'b000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_result  <= '0;
      r_carry   <= 1'b0;
      r_cout    <= 1'b0;
      r_k       <= '0;
      r_cnt     <= '0;
      r_add_a   <= '0;
      r_add_b   <= '0;
      r_add_cin <= 1'b0;
    end else begin
      r_add_a   <= '0;
      r_add_b   <= '0;
      r_add_cin <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start_i) begin
            r_a       <= a_i;
            r_b       <= w_bx;
            r_carry   <= w_cin0;
            r_k       <= '0;
            r_add_a   <= a_i[7:0];
            r_add_b   <= w_bx[7:0];
            r_add_cin <= w_cin0;
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt   <= 2'(ADD_LAT);
          r_state <= WAIT;
        end
        WAIT: begin
          r_cnt <= r_cnt - 2'd1;
          if (r_cnt == 2'd1) begin
            r_result[w_k_ofs +: 8] <= add_sum_i;
            r_carry                <= add_cout_i;
            if (w_last) begin
              r_cout  <= add_cout_i;
              r_state <= DONE;
            end else begin
              // Next byte is issued straight from the adder's carry.
              r_k       <= w_knext;
              r_add_a   <= r_a[w_knext_ofs +: 8];
              r_add_b   <= r_b[w_knext_ofs +: 8];
              r_add_cin <= add_cout_i;
              r_state   <= ISSUE;
            end
          end
        end
        DONE: begin
          if (ack_i) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready_o   = (r_state == IDLE);
  assign valid_o   = (r_state == DONE);
  assign result_o  = r_result;
  assign carry_o   = r_cout;
  assign add_a_o   = r_add_a;
  assign add_b_o   = r_add_b;
  assign add_cin_o = r_add_cin;

endmodule

// File: tb/tb_somador_seq.sv
// Bench for somador_seq: two builds (ADD_LAT 1 and 2) with behavioural
// adders, checked against an arithmetic reference of the full operation.
module tb_somador_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic op_s = 1'b0;
  logic cin_s = 1'b0;
  logic [31:0] a_s = '0;
  logic [31:0] b_s = '0;
  logic start1 = 1'b0, ack1 = 1'b0;
  logic start2 = 1'b0, ack2 = 1'b0;

  logic ready1, valid1, carry1, ac1, co1;
  logic [31:0] result1;
  logic [7:0] aa1, ab1, sum1;
  logic ready2, valid2, carry2, ac2, co2;
  logic [31:0] result2;
  logic [7:0] aa2, ab2, sum2;
  logic [8:0] s2_stage;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  somador_seq #(.NBYTES(4), .ADD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start_i(start1), .op_i(op_s), .cin_i(cin_s),
    .a_i(a_s), .b_i(b_s), .ready_o(ready1), .valid_o(valid1),
    .ack_i(ack1), .result_o(result1), .carry_o(carry1),
    .add_a_o(aa1), .add_b_o(ab1), .add_cin_o(ac1),
    .add_sum_i(sum1), .add_cout_i(co1)
  );

  somador_seq #(.NBYTES(4), .ADD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start_i(start2), .op_i(op_s), .cin_i(cin_s),
    .a_i(a_s), .b_i(b_s), .ready_o(ready2), .valid_o(valid2),
    .ack_i(ack2), .result_o(result2), .carry_o(carry2),
    .add_a_o(aa2), .add_b_o(ab2), .add_cin_o(ac2),
    .add_sum_i(sum2), .add_cout_i(co2)
  );

  // Behavioural registered 8-bit adders with latency 1 and 2.
  always @(posedge clk or posedge rst) begin
    if (rst) {co1, sum1} <= '0;
    else {co1, sum1} <= {1'b0, aa1} + {1'b0, ab1} + {8'd0, ac1};
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_stage <= '0;
      {co2, sum2} <= '0;
    end else begin
      s2_stage <= {1'b0, aa2} + {1'b0, ab2} + {8'd0, ac2};
      {co2, sum2} <= s2_stage;
    end
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [32:0] ref_op(input logic op, input logic cin,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic [32:0] bb;
    bb = op ? {1'b0, ~b} : {1'b0, b};
    return {1'b0, a} + bb + 33'(op ? 1'b1 : cin);
  endfunction

  // Expected adder drive while byte k is being issued.
  function automatic logic [16:0] issue_exp(input logic op, input logic cin,
                                            input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int k);
    logic [63:0] aa, bb, mask, low;
    logic [31:0] bx;
    logic c;
    bx = op ? ~b : b;
    c = op ? 1'b1 : cin;
    mask = (64'd1 << (8 * k)) - 64'd1;
    aa = {32'd0, a};
    bb = {32'd0, bx};
    low = (aa & mask) + (bb & mask) + {63'd0, c};
    return {a[8*k +: 8], bx[8*k +: 8], low[8*k]};
  endfunction

  function automatic logic [16:0] bus(input int lat);
    return (lat == 1) ? {aa1, ab1, ac1} : {aa2, ab2, ac2};
  endfunction

  function automatic logic get_valid(input int lat);
    return (lat == 1) ? valid1 : valid2;
  endfunction

  function automatic logic get_ready(input int lat);
    return (lat == 1) ? ready1 : ready2;
  endfunction

  function automatic logic [32:0] get_res(input int lat);
    return (lat == 1) ? {carry1, result1} : {carry2, result2};
  endfunction

  task automatic set_start(input int lat, input logic v);
    if (lat == 1) start1 = v;
    else start2 = v;
  endtask

  task automatic set_ack(input int lat, input logic v);
    if (lat == 1) ack1 = v;
    else ack2 = v;
  endtask

  task automatic run(input int lat, input logic op, input logic cin,
                     input logic [31:0] a, input logic [31:0] b,
                     input int hold);
    logic [32:0] exp;
    logic [16:0] ebus;
    int per, n;
    exp = ref_op(op, cin, a, b);
    per = 1 + lat;
    op_s = op;
    cin_s = cin;
    a_s = a;
    b_s = b;
    set_start(lat, 1'b1);
    tick();
    set_start(lat, 1'b0);
    a_s = $urandom;
    b_s = $urandom;
    op_s = 1'($urandom);
    cin_s = 1'($urandom);
    n = 0;
    while (!get_valid(lat) && n < 40) begin
      ebus = (n % per == 0 && n / per < 4)
           ? issue_exp(op, cin, a, b, n / per) : 17'd0;
      check("adder_drive", 64'(bus(lat)), 64'(ebus));
      tick();
      n++;
    end
    check("latency", 64'(n), 64'(4 * per));
    check("result", 64'(get_res(lat)), 64'(exp));
    for (int i = 0; i < hold; i++) begin
      set_start(lat, 1'b1);
      a_s = $urandom;
      tick();
      check("hold_valid", 64'(get_valid(lat)), 64'd1);
      check("hold_ready", 64'(get_ready(lat)), 64'd0);
      check("hold_result", 64'(get_res(lat)), 64'(exp));
    end
    set_ack(lat, 1'b1);
    set_start(lat, hold > 0);
    tick();
    set_ack(lat, 1'b0);
    set_start(lat, 1'b0);
    check("ack_ready", 64'(get_ready(lat)), 64'd1);
    check("ack_valid", 64'(get_valid(lat)), 64'd0);
    check("ack_idle_bus", 64'(bus(lat)), 64'd0);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    check("rst_ready", 64'({ready1, ready2}), 64'd3);
    check("rst_valid", 64'({valid1, valid2}), 64'd0);
    check("rst_result", 64'({carry1, result1}), 64'd0);
    check("rst_bus", 64'({aa1, ab1, ac1}), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    run(1, 1'b0, 1'b0, 32'h0000_00FF, 32'h0000_0001, 0);
    run(1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run(1, 1'b1, 1'b0, 32'h0000_0005, 32'h0000_0007, 0);
    run(1, 1'b0, 1'b1, $urandom, $urandom, 5);

    // Abort during byte-2 WAIT.
    op_s = 1'b0;
    a_s = $urandom;
    b_s = $urandom;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    #1;
    check("abort_ready", 64'(ready1), 64'd1);
    check("abort_valid", 64'(valid1), 64'd0);
    check("abort_result", 64'({carry1, result1}), 64'd0);
    check("abort_bus", 64'({aa1, ab1, ac1}), 64'd0);
    tick();
    check("abort_hold", 64'({valid1, carry1, result1}), 64'd0);
    rst = 1'b0;
    tick();
    run(1, 1'b0, 1'b0, 32'h1234_5678, 32'h1111_1111, 0);

    for (int i = 0; i < 6; i++)
      run(1, 1'($urandom), 1'($urandom), $urandom, $urandom, 0);

    run(2, 1'b0, 1'b0, 32'h0101_0101, 32'h0101_0101, 0);
    for (int i = 0; i < 2; i++)
      run(2, 1'($urandom), 1'($urandom), $urandom, $urandom, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/somador_seq.md
Name: somador_seq

Overview:
- Multi-precision sequencer wrapped around the existing 8-bit registered adder `somador`.
- Accepts NBYTES-wide operands and a mode bit (add or subtract) through a start/ready handshake.
- Feeds the adder one byte per pass, LSB first, and chains each byte's carry into the next pass.
- Assembles the full-width result and holds it on a valid/ack output handshake. Sits between the chip control logic and the `somador` instance.

Parameters:
- NBYTES, 4: operand width in bytes (W = 8*NBYTES); legal range 2..8.
- ADD_LAT, 1: cycles from the adder sampling its inputs to `sum_o`/`carry_o` being valid; legal range 1..3.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  request; accepted on a rising edge when start_i=1 and ready_o=1.
- op_i  in  1  0 = add, 1 = subtract (a - b); sampled on accept.
- cin_i  in  1  carry-in for byte 0 in add mode; ignored in subtract mode; sampled on accept.
- a_i  in  W  operand A; sampled on accept.
- b_i  in  W  operand B; sampled on accept.
- ready_o  out  1  high only in IDLE.
- valid_o  out  1  result valid; high only in DONE.
- ack_i  in  1  consumer accepts the result when valid_o=1.
- result_o  out  W  assembled sum or difference.
- carry_o  out  1  raw carry out of the MSB byte; in subtract mode, 1 = no borrow.
- add_a_o  out  8  operand byte driven to the adder `a_i`.
- add_b_o  out  8  operand byte driven to the adder `b_i`; already inverted in subtract mode.
- add_cin_o  out  1  driven to the adder `carry_i`.
- add_sum_i  in  8  from the adder `sum_o`.
- add_cout_i  in  1  from the adder `carry_o`.

Behaviour:
- Reset values (asynchronous, immediate on rst=1):
  - state = IDLE, ready_o = 1, valid_o = 0.
  - result_o = 0, carry_o = 0.
  - add_a_o = 0, add_b_o = 0, add_cin_o = 0.
  - byte index = 0, latency counter = 0.
- FSM states:
  - IDLE: ready_o = 1. On accept, latch a_i and b_i (b_i inverted when op_i = 1). Set the carry register to cin_i (add) or 1 (subtract). Clear byte index k to 0. Go to ISSUE.
  - ISSUE (1 cycle): drive add_a_o = A[8k+7:8k], add_b_o = B'[8k+7:8k], add_cin_o = carry register. Load the latency counter with ADD_LAT. Go to WAIT.
  - WAIT (ADD_LAT cycles): decrement the counter each cycle. On the edge ending the final WAIT cycle:
    - capture add_sum_i into result byte k;
    - capture add_cout_i into the carry register;
    - if k = NBYTES-1, go to DONE with carry_o = captured carry;
    - otherwise increment k and go to ISSUE.
  - DONE: valid_o = 1; result_o and carry_o hold stable. When ack_i = 1, go to IDLE on that edge.
- add_a_o, add_b_o and add_cin_o are 0 in every state except ISSUE. The adder is not required to hold its output beyond ADD_LAT.
- Latency: valid_o rises NBYTES*(1+ADD_LAT) edges after the accept edge (8 for the defaults). ready_o returns the cycle after the ack edge. Peak throughput is one operation per NBYTES*(1+ADD_LAT)+2 cycles.
- Width rules:
  - every byte sum is modulo 256 and its carry is passed to the next byte;
  - result_o is the full sum modulo 2^W;
  - subtract computes A + ~B + 1.
- result_o is updated byte by byte while busy but carries no meaning unless valid_o = 1.
- Boundary conditions:
  - start_i while ready_o = 0 is ignored; nothing is queued.
  - ack_i while valid_o = 0 is ignored.
  - ack_i and start_i together in DONE: only the ack takes effect; start is not accepted that cycle.
  - Operand changes after accept have no effect.
  - rst mid-operation aborts it. Any adder result still in flight is discarded, and outputs hold reset values until rst releases. The first accept after release behaves normally.

Decomposition:
- somador_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, DONE};
  - OP_ADD = 1'b0 and OP_SUB = 1'b1;
  - the default NBYTES and ADD_LAT.
- No sub-module is required; a single FSM plus datapath.
- The chip top inverts rst for the adder's rst_n.

Test Plan:
- Add 0x000000FF + 0x00000001, cin 0 -> result_o 0x00000100, carry_o 0, valid_o high 8 edges after accept; add_cin_o = 1 in the ISSUE cycle for byte 1.
- Add 0xFFFFFFFF + 0x00000001, cin 0 -> result_o 0x00000000, carry_o 1; carry chains through all 4 bytes.
- Subtract 0x00000005 - 0x00000007 -> result_o 0xFFFFFFFE, carry_o 0; add_b_o = 0xF8 and add_cin_o = 1 for byte 0.
- Backpressure: hold ack_i low 5 cycles after valid_o, pulse start_i meanwhile -> result_o and valid_o stable, pulses ignored; ack -> ready_o = 1 the next cycle.
- Assert rst during the byte-2 WAIT -> all outputs at reset values within the cycle. After release, 0x12345678 + 0x11111111 -> 0x23456789, carry_o 0.
- ADD_LAT = 2 build, add 0x01010101 + 0x01010101 -> result_o 0x02020202, valid_o high 12 edges after accept; each ISSUE is followed by exactly 2 WAIT cycles.
